// File: rtl/lsu_mem.sv
// Purpose : single-ported load/store unit with an internal byte-lane-writable word array.
// Latency : resp_valid LAT edges after a legal accept; cycle right after accept for errors.
// Backpr. : one request in flight; req_ready only in IDLE; response held until resp_ready.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_we, req_width      store flag, size/extension code (B,H,W,D,BU,HU,WU)
//   req_addr, req_wdata    byte address, right-aligned store data
//   resp_valid/resp_ready  response handshake
//   resp_rdata, resp_err   extended load data (0 for stores/errors), error flag
module lsu_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_width,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 2;
    // One extra bit so an array that fills the whole address space never wraps to 0.
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * NB);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    // Request fields captured at the accept edge.
    logic                we_q;
    logic [1:0]          sz_q;
    logic                uns_q;
    logic [OFF_W-1:0]    off_q;
    logic [DATA_W-1:0]   word_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                accept;
    logic [1:0]          req_sz;
    logic [2:0]          align_mask;
    logic [7:0]          size_mask;
    logic                req_illegal, req_misal, req_oor, req_bad;
    logic [IDX_W-1:0]    req_idx;
    logic [OFF_W-1:0]    req_off;
    logic [NB-1:0]       req_be;
    logic [DATA_W-1:0]   req_wsh;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_off   = req_addr[OFF_W-1:0];
    // Codes 4/5/6 (unsigned B/H/W) share the log2 size of codes 0/1/2.
    assign req_sz    = req_width[1:0];

    always_comb begin
        align_mask = 3'b000;
        size_mask  = 8'h01;
        case (req_sz)
            2'd0:    begin align_mask = 3'b000; size_mask = 8'h01; end
            2'd1:    begin align_mask = 3'b001; size_mask = 8'h03; end
            2'd2:    begin align_mask = 3'b011; size_mask = 8'h0F; end
            default: begin align_mask = 3'b111; size_mask = 8'hFF; end
        endcase
        req_illegal = (req_width == 3'd7) ||
                      ((DATA_W == 32) && ((req_width == 3'd3) || (req_width == 3'd6)));
        req_misal   = (req_addr[2:0] & align_mask) != 3'b000;
        req_oor     = {1'b0, req_addr} >= MEM_BYTES;
        req_bad     = req_illegal || req_misal || req_oor;
        req_be      = NB'(size_mask << req_off);
        req_wsh     = req_wdata << {req_off, 3'b000};
    end

    // ------------------------------------------------------------------
    // Array: byte-lane write and synchronous read, both at the accept edge.
    // Not reset, so contents survive rst.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            word_q <= mem_q[req_idx];
            we_q   <= req_we;
            sz_q   <= req_sz;
            uns_q  <= req_width[2];
            off_q  <= req_off;
            if (req_we && !req_bad) begin
                for (int b = 0; b < NB; b++) begin
                    if (req_be[b]) begin
                        mem_q[req_idx][8*b +: 8] <= req_wsh[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load formatting: align to bit 0, then push the field to the top and
    // shift back down arithmetically or logically to extend it.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ld_shift, ld_left, ld_data;
    logic [6:0]        ext_sh;

    always_comb begin
        ld_shift = word_q >> {off_q, 3'b000};
        ext_sh   = 7'(DATA_W) - (7'd8 << sz_q);
        ld_left  = ld_shift << ext_sh;
        if (uns_q) begin
            ld_data = ld_left >> ext_sh;
        end else begin
            ld_data = DATA_W'($signed(ld_left) >>> ext_sh);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(LAT - 1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : ld_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench: a 32-bit LAT=1 instance and a 64-bit LAT=3 instance share clk/rst.
// Latency is counted in rising edges from the accept edge to the first cycle with
// resp_valid high: a legal access reports LAT, an error reports 0 (valid in the
// cycle right after the accept cycle).
module tb_lsu_mem;

    logic clk;
    logic rst;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [2:0]  a_req_width;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [2:0]  b_req_width;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err;
    logic [63:0] b_resp_rdata;

    int n_pass  = 0;
    int n_total = 0;

    lsu_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LAT(1)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_width(a_req_width), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    lsu_mem #(.DATA_W(64), .ADDR_W(32), .DEPTH(256), .LAT(3)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_width(b_req_width), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full transaction on instance A; entered and left at #1 after a rising edge.
    task automatic a_txn(input logic we, input logic [2:0] w, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic err, output int lat);
        int n;
        n = 0;
        while (!a_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        a_req_valid = 1'b1; a_req_we = we; a_req_width = w;
        a_req_addr = addr; a_req_wdata = wd;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        n = 0;
        while (!a_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        lat = a_resp_valid ? n : -1;
        rd  = a_resp_rdata;
        err = a_resp_err;
        @(posedge clk); #1;
    endtask

    task automatic b_txn(input logic we, input logic [2:0] w, input logic [31:0] addr,
                         input logic [63:0] wd, output logic [63:0] rd,
                         output logic err, output int lat);
        int n;
        n = 0;
        while (!b_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        b_req_valid = 1'b1; b_req_we = we; b_req_width = w;
        b_req_addr = addr; b_req_wdata = wd;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n = 0;
        while (!b_resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        lat = b_resp_valid ? n : -1;
        rd  = b_resp_rdata;
        err = b_resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (a_req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", a_req_ready); else n_pass++;
        n_total++; if (a_resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", a_resp_valid); else n_pass++;
        n_total++; if (a_resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %h want 0", a_resp_rdata); else n_pass++;
        n_total++; if (a_resp_err !== 1'b0) $display("FAIL rst_resp_err got %b want 0", a_resp_err); else n_pass++;
        n_total++; if (b_req_ready !== 1'b0) $display("FAIL rst_b_req_ready got %b want 0", b_req_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (a_req_ready !== 1'b1) $display("FAIL post_rst_req_ready got %b want 1", a_req_ready); else n_pass++;
        n_total++; if (b_req_ready !== 1'b1) $display("FAIL post_rst_b_req_ready got %b want 1", b_req_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_sign_ext();
        logic [31:0] rd; logic err; int lat;
        a_txn(1'b1, 3'd2, 32'h10, 32'h8000_00FF, rd, err, lat);
        n_total++; if (err !== 1'b0 || rd !== 32'h0) $display("FAIL st_w resp got err=%b rd=%h want 0/0", err, rd); else n_pass++;
        n_total++; if (lat !== 1) $display("FAIL st_w latency got %0d want 1", lat); else n_pass++;
        a_txn(1'b0, 3'd0, 32'h10, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hFFFF_FFFF || err !== 1'b0) $display("FAIL ld_b got %h/%b want ffffffff/0", rd, err); else n_pass++;
        n_total++; if (lat !== 1) $display("FAIL ld_b latency got %0d want 1", lat); else n_pass++;
        a_txn(1'b0, 3'd4, 32'h10, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'h0000_00FF) $display("FAIL ld_bu got %h want 000000ff", rd); else n_pass++;
        a_txn(1'b0, 3'd1, 32'h12, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hFFFF_8000) $display("FAIL ld_h got %h want ffff8000", rd); else n_pass++;
        a_txn(1'b0, 3'd5, 32'h12, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'h0000_8000) $display("FAIL ld_hu got %h want 00008000", rd); else n_pass++;
        a_txn(1'b0, 3'd2, 32'h10, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'h8000_00FF) $display("FAIL ld_w got %h want 800000ff", rd); else n_pass++;
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic err; int lat;
        a_txn(1'b1, 3'd2, 32'h20, 32'h1122_3344, rd, err, lat);
        a_txn(1'b1, 3'd1, 32'h22, 32'h5555_ABCD, rd, err, lat);
        a_txn(1'b0, 3'd2, 32'h20, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hABCD_3344) $display("FAIL st_h_merge got %h want abcd3344", rd); else n_pass++;
        a_txn(1'b1, 3'd0, 32'h21, 32'hFFFF_FF77, rd, err, lat);
        a_txn(1'b0, 3'd2, 32'h20, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hABCD_7744) $display("FAIL st_b_merge got %h want abcd7744", rd); else n_pass++;
        a_txn(1'b0, 3'd0, 32'h23, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hFFFF_FFAB) $display("FAIL ld_b_lane3 got %h want ffffffab", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat;
        a_txn(1'b0, 3'd2, 32'h13, 32'h0, rd, err, lat);
        n_total++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL misal_w got err=%b rd=%h want 1/0", err, rd); else n_pass++;
        n_total++; if (lat !== 0) $display("FAIL misal_w latency got %0d want 0", lat); else n_pass++;
        a_txn(1'b1, 3'd2, 32'h11, 32'hFFFF_FFFF, rd, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL misal_st err got %b want 1", err); else n_pass++;
        a_txn(1'b0, 3'd2, 32'h10, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'h8000_00FF) $display("FAIL misal_st_nowrite got %h want 800000ff", rd); else n_pass++;
        a_txn(1'b0, 3'd1, 32'h21, 32'h0, rd, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL misal_h err got %b want 1", err); else n_pass++;
        a_txn(1'b0, 3'd3, 32'h20, 32'h0, rd, err, lat);
        n_total++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL illegal_d32 got err=%b rd=%h want 1/0", err, rd); else n_pass++;
        a_txn(1'b0, 3'd6, 32'h20, 32'h0, rd, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL illegal_wu32 err got %b want 1", err); else n_pass++;
        a_txn(1'b1, 3'd2, 32'h0, 32'h0, rd, err, lat);
        a_txn(1'b1, 3'd2, 32'h1000, 32'h1234_5678, rd, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL oor_st err got %b want 1", err); else n_pass++;
        a_txn(1'b0, 3'd2, 32'h0, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'h0) $display("FAIL oor_no_alias got %h want 00000000", rd); else n_pass++;
        a_txn(1'b1, 3'd2, 32'hFFC, 32'hCAFE_F00D, rd, err, lat);
        n_total++; if (err !== 1'b0) $display("FAIL last_word_st err got %b want 0", err); else n_pass++;
        a_txn(1'b0, 3'd2, 32'hFFC, 32'h0, rd, err, lat);
        n_total++; if (rd !== 32'hCAFE_F00D) $display("FAIL last_word_ld got %h want cafef00d", rd); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] rd; logic err; int lat; int n;
        logic rdy_low, stable;
        b_txn(1'b1, 3'd3, 32'h8, 64'h8000_0000_1234_5678, rd, err, lat);
        n_total++; if (err !== 1'b0 || lat !== 3) $display("FAIL b_st_d got err=%b lat=%0d want 0/3", err, lat); else n_pass++;

        b_resp_ready = 1'b0;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_width = 3'd3; b_req_addr = 32'h8; b_req_wdata = 64'h0;
        @(posedge clk); #1;
        // Same request fields left on the bus as a store of zeros: must not be taken.
        b_req_we = 1'b1;
        rdy_low = 1'b1; n = 0;
        while (!b_resp_valid && n < 20) begin
            if (b_req_ready !== 1'b0) rdy_low = 1'b0;
            @(posedge clk); #1; n++;
        end
        n_total++; if (n !== 3) $display("FAIL bp_latency got %0d want 3", n); else n_pass++;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (b_resp_valid !== 1'b1 || b_resp_rdata !== 64'h8000_0000_1234_5678 ||
                b_resp_err !== 1'b0) stable = 1'b0;
            if (b_req_ready !== 1'b0) rdy_low = 1'b0;
            @(posedge clk); #1;
        end
        n_total++; if (stable !== 1'b1) $display("FAIL bp_hold_stable got %b want 1", stable); else n_pass++;
        n_total++; if (rdy_low !== 1'b1) $display("FAIL bp_req_ready_low got %b want 1", rdy_low); else n_pass++;
        b_req_valid = 1'b0; b_resp_ready = 1'b1;
        @(posedge clk); #1;
        n_total++; if (b_resp_valid !== 1'b0) $display("FAIL bp_valid_drop got %b want 0", b_resp_valid); else n_pass++;
        b_txn(1'b0, 3'd3, 32'h8, 64'h0, rd, err, lat);
        n_total++; if (rd !== 64'h8000_0000_1234_5678) $display("FAIL bp_not_latched got %h want 8000000012345678", rd); else n_pass++;
    endtask

    task automatic test_wide();
        logic [63:0] rd; logic err; int lat;
        b_txn(1'b0, 3'd6, 32'hC, 64'h0, rd, err, lat);
        n_total++; if (rd !== 64'h0000_0000_8000_0000 || err !== 1'b0) $display("FAIL ld_wu64 got %h/%b want 0000000080000000/0", rd, err); else n_pass++;
        b_txn(1'b0, 3'd2, 32'hC, 64'h0, rd, err, lat);
        n_total++; if (rd !== 64'hFFFF_FFFF_8000_0000) $display("FAIL ld_w64 got %h want ffffffff80000000", rd); else n_pass++;
        b_txn(1'b0, 3'd2, 32'h8, 64'h0, rd, err, lat);
        n_total++; if (rd !== 64'h0000_0000_1234_5678) $display("FAIL ld_w64_lo got %h want 0000000012345678", rd); else n_pass++;
        b_txn(1'b0, 3'd4, 32'hF, 64'h0, rd, err, lat);
        n_total++; if (rd !== 64'h80) $display("FAIL ld_bu64 got %h want 0000000000000080", rd); else n_pass++;
        b_txn(1'b0, 3'd1, 32'hE, 64'h0, rd, err, lat);
        n_total++; if (rd !== 64'hFFFF_FFFF_FFFF_8000) $display("FAIL ld_h64 got %h want ffffffffffff8000", rd); else n_pass++;
        b_txn(1'b0, 3'd7, 32'h8, 64'h0, rd, err, lat);
        n_total++; if (err !== 1'b1 || rd !== 64'h0 || lat !== 0) $display("FAIL code7 got err=%b rd=%h lat=%0d want 1/0/0", err, rd, lat); else n_pass++;
        b_txn(1'b0, 3'd3, 32'h4, 64'h0, rd, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL misal_d err got %b want 1", err); else n_pass++;
        b_txn(1'b0, 3'd3, 32'h800, 64'h0, rd, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL oor64 err got %b want 1", err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic err; int lat; logic seen;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_width = 3'd3;
        b_req_addr = 32'h40; b_req_wdata = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_total++; if (b_req_ready !== 1'b1) $display("FAIL mid_rst_req_ready got %b want 1", b_req_ready); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (b_resp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL mid_rst_no_resp got %b want 0", seen); else n_pass++;
        b_txn(1'b0, 3'd3, 32'h40, 64'h0, rd, err, lat);
        n_total++; if (rd !== 64'h0123_4567_89AB_CDEF || err !== 1'b0) $display("FAIL mid_rst_data got %h/%b want 0123456789abcdef/0", rd, err); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_width = 3'd0;
        a_req_addr = 32'h0; a_req_wdata = 32'h0; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_width = 3'd0;
        b_req_addr = 32'h0; b_req_wdata = 64'h0; b_resp_ready = 1'b1;

        test_reset();
        test_sign_ext();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_wide();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
